// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and sizes for the digit scan sequencer.
// The select width covers the channel count.
package scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_e;
endpackage

// File: rtl/digit_scan_ctrl_mask_next_sel.sv
// Combinational pick of the next enabled channel strictly after cur, wrapping round.
// Calling it with cur=NUM_CH-1 returns the lowest enabled channel.
module mask_next_sel
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap,
  output logic              none
);
  // cand[k] is the channel k+1 steps after cur; the last candidate is cur itself.
  logic [SEL_W-1:0]  cand [NUM_CH];
  logic [NUM_CH-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign cand[gi] = cur + SEL_W'(gi + 1);
      assign hit[gi]  = mask[cand[gi]];
    end
  endgenerate

  always_comb begin
    nxt = cur;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) nxt = cand[i];
    end
  end

  assign wrap = (nxt <= cur);
  assign none = (mask == '0);
endmodule

// File: rtl/digit_scan_ctrl.sv
// Round-robin scan sequencer: dwell on each enabled channel, blank between channels,
// skip masked channels and pulse frame_tick when the scan wraps.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] digit_mask,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_valid,
  output logic              frame_tick
);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               frame_tick_q, frame_tick_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SEL_W-1:0]   pick_cur;
  logic [SEL_W-1:0]   pick_nxt;
  logic               pick_wrap;
  logic               mask_none;

  // From IDLE the search starts after the top channel, giving the lowest set bit.
  assign pick_cur = (state_q == IDLE) ? SEL_W'(NUM_CH - 1) : sel_q;

  mask_next_sel u_pick (
    .mask (digit_mask),
    .cur  (pick_cur),
    .nxt  (pick_nxt),
    .wrap (pick_wrap),
    .none (mask_none)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_valid_d  = sel_valid_q;
    frame_tick_d = 1'b0;
    cnt_d        = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        sel_valid_d = 1'b0;
        if (en && !mask_none) begin
          state_d     = DWELL;
          sel_d       = pick_nxt;
          sel_valid_d = 1'b1;
        end
      end
      DWELL: begin
        if (!en || mask_none) begin
          state_d     = IDLE;
          cnt_d       = '0;
          sel_valid_d = 1'b0;
        end else if (cnt_q == DWELL_LAST || !digit_mask[sel_q]) begin
          // A channel masked mid-dwell ends its dwell immediately.
          cnt_d = '0;
          if (HAS_BLANK) begin
            state_d     = BLANK;
            sel_valid_d = 1'b0;
          end else begin
            sel_d        = pick_nxt;
            frame_tick_d = pick_wrap;
            sel_valid_d  = 1'b1;
          end
        end
      end
      BLANK: begin
        if (!en || mask_none) begin
          state_d     = IDLE;
          cnt_d       = '0;
          sel_valid_d = 1'b0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d      = DWELL;
          cnt_d        = '0;
          sel_d        = pick_nxt;
          frame_tick_d = pick_wrap;
          sel_valid_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        sel_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      frame_tick_q <= frame_tick_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: one instance with a blanking gap, one without,
// both checked against a behavioural scan model.
module tb_digit_scan_ctrl;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_mask;
  logic [1:0] sel_a, sel_b;
  logic       sv_a, sv_b, ft_a, ft_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask),
    .sel(sel_a), .sel_valid(sv_a), .frame_tick(ft_a)
  );

  digit_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask),
    .sel(sel_b), .sel_valid(sv_b), .frame_tick(ft_b)
  );

  // Model: per instance, whether scanning, whether lit, cycles left in phase, channel.
  int m_blank [2] = '{2, 0};
  bit m_active[2];
  bit m_lit   [2];
  bit m_tick  [2];
  int m_left  [2];
  int m_ch    [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_lit[i] = 0; m_tick[i] = 0; m_left[i] = 0; m_ch[i] = 0;
    end
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int k = 0; k < 4; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic int next_ch(input int ch, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(ch + k) % 4]) return (ch + k) % 4;
    return ch;
  endfunction

  task automatic advance(input int i);
    int nc;
    nc = next_ch(m_ch[i], digit_mask);
    m_tick[i] = (nc <= m_ch[i]);
    m_ch[i]   = nc;
    m_lit[i]  = 1;
    m_left[i] = DWELL;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_active[i] = 0; m_lit[i] = 0; m_tick[i] = 0; m_left[i] = 0; m_ch[i] = 0;
      end else begin
        m_tick[i] = 0;
        if (!m_active[i]) begin
          if (en && digit_mask != 0) begin
            m_ch[i] = lowest(digit_mask);
            m_active[i] = 1; m_lit[i] = 1; m_left[i] = DWELL;
          end
        end else if (!en || digit_mask == 0) begin
          m_active[i] = 0; m_lit[i] = 0;
        end else begin
          m_left[i]--;
          if (m_lit[i]) begin
            if (m_left[i] == 0 || !digit_mask[m_ch[i]]) begin
              if (m_blank[i] > 0) begin
                m_lit[i] = 0; m_left[i] = m_blank[i];
              end else advance(i);
            end
          end else if (m_left[i] == 0) advance(i);
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a.sel",        sel_a, m_ch[0]);
    check("a.sel_valid",  sv_a,  int'(m_active[0] && m_lit[0]));
    check("a.frame_tick", ft_a,  int'(m_tick[0]));
    check("b.sel",        sel_b, m_ch[1]);
    check("b.sel_valid",  sv_b,  int'(m_active[1] && m_lit[1]));
    check("b.frame_tick", ft_b,  int'(m_tick[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    bit         en;
    logic [3:0] mask;
    int         ncyc;
    logic [3:0] allowed;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c, p;
    logic [3:0] al;

    vecs[0] = '{en: 1'b0, mask: 4'b1111, ncyc: 2,  allowed: 4'b1111};
    vecs[1] = '{en: 1'b1, mask: 4'b1010, ncyc: 40, allowed: 4'b1010};
    vecs[2] = '{en: 1'b0, mask: 4'b1010, ncyc: 2,  allowed: 4'b1010};
    vecs[3] = '{en: 1'b1, mask: 4'b0100, ncyc: 30, allowed: 4'b0100};
    vecs[4] = '{en: 1'b0, mask: 4'b0000, ncyc: 2,  allowed: 4'b1111};
    vecs[5] = '{en: 1'b1, mask: 4'b1111, ncyc: 30, allowed: 4'b1111};
    vecs[6] = '{en: 1'b1, mask: 4'b0000, ncyc: 3,  allowed: 4'b1111};
    vecs[7] = '{en: 1'b1, mask: 4'b0011, ncyc: 20, allowed: 4'b0011};

    // Reset held with scanning requested.
    rst_n = 1'b0; en = 1'b1; digit_mask = 4'b1111;
    model_reset();
    repeat (3) cyc();
    check("rst.sel", sel_a, 0);
    check("rst.sel_valid", sv_a, 0);
    check("rst.frame_tick", ft_a, 0);
    rst_n = 1'b1;

    // Full scan 0,1,2,3,0: 4 lit, 2 dark per channel, tick on the wrap.
    for (int k = 1; k <= 32; k++) begin
      cyc();
      c = (k - 1) / 6;
      p = (k - 1) % 6;
      check("scan.sel", sel_a, c % 4);
      check("scan.sel_valid", sv_a, int'(p < 4));
      check("scan.frame_tick", ft_a, int'(p == 0 && c > 0 && c % 4 == 0));
    end

    // Asynchronous reset mid-dwell on channel 1, observed between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.sel", sel_a, 0);
    check("arst.sel_valid", sv_a, 0);
    check("arst.frame_tick", ft_a, 0);
    check("arst.b_sel", sel_b, 0);
    check("arst.b_sel_valid", sv_b, 0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Current channel masked mid-dwell, then en dropped mid-blank.
    for (int k = 1; k <= 8; k++) cyc();
    digit_mask = 4'b1101;
    cyc();
    check("cut.sel_valid", sv_a, 0);
    check("cut.sel", sel_a, 1);
    cyc();
    cyc();
    check("cut.next_sel", sel_a, 2);
    check("cut.next_valid", sv_a, 1);
    repeat (4) cyc();
    check("cut.blank", sv_a, 0);
    en = 1'b0;
    repeat (3) begin
      cyc();
      check("off.sel_valid", sv_a, 0);
      check("off.sel_held", sel_a, 2);
    end
    en = 1'b1; digit_mask = 4'b1111;
    cyc();
    check("restart.sel", sel_a, 0);
    check("restart.sel_valid", sv_a, 1);
    check("restart.frame_tick", ft_a, 0);

    // Table of steady input phases.
    for (int v = 0; v < 8; v++) begin
      en = vecs[v].en;
      digit_mask = vecs[v].mask;
      al = vecs[v].allowed;
      for (int j = 0; j < vecs[v].ncyc; j++) begin
        cyc();
        if (sv_a) check("tbl.a_allowed", int'(al[sel_a]), 1);
        if (sv_b) check("tbl.b_allowed", int'(al[sel_b]), 1);
        if (vecs[v].en && vecs[v].mask != 0 && j >= 1)
          check("tbl.b_always_valid", sv_b, 1);
      end
    end

    // Randomised enable and mask changes.
    for (int n = 0; n < 500; n++) begin
      if (en ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 4) == 0)) en = ~en;
      if ($urandom_range(0, 14) == 0) digit_mask = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
